// File: rtl/connect4_game_ctrl_if.sv
// Move handshake and display-facing status bundle of the Connect4 game controller.
interface connect4_game_ctrl_if;
  logic        start_i;
  logic        move_valid_i;
  logic [2:0]  move_col_i;
  logic        move_ready_o;
  logic        move_reject_o;
  logic [83:0] board_state_o;
  logic [83:0] winner_play_o;
  logic        theres_a_winner_o;
  logic        draw_o;
  logic [2:0]  current_state_o;

  modport master (
    output start_i, move_valid_i, move_col_i,
    input  move_ready_o, move_reject_o, board_state_o, winner_play_o,
           theres_a_winner_o, draw_o, current_state_o
  );

  modport slave (
    input  start_i, move_valid_i, move_col_i,
    output move_ready_o, move_reject_o, board_state_o, winner_play_o,
           theres_a_winner_o, draw_o, current_state_o
  );
endinterface

// File: rtl/connect4_game_ctrl.sv
// Connect4 game controller: owns the board, drops pieces, scans one 4-cell window per cycle.
// Optional turn-timeout auto-move is built when TURN_TIMEOUT_EN is defined.
module connect4_game_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 500_000_000
) (
  input  logic                clk,
  input  logic                rst_n,
  connect4_game_ctrl_if.slave bus
);
  localparam int unsigned ROWS     = 6;
  localparam int unsigned COLS     = 7;
  localparam int unsigned CELLS    = ROWS * COLS;
  localparam int unsigned BOARD_W  = 2 * CELLS;
  localparam int unsigned IDX_W    = 7;
  localparam int unsigned MOVES_W  = 6;
  localparam int unsigned LAST_WIN = 68;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_PLAY1 = 3'd1;
  localparam logic [2:0] ST_PLAY2 = 3'd2;
  localparam logic [2:0] ST_OVER  = 3'd3;

  typedef enum logic [1:0] {PH_IDLE, PH_ACCEPT, PH_SCAN, PH_OVER} phase_t;

  phase_t               r_phase, w_phase;
  logic                 r_player, w_player;   // 0 = player 1, 1 = player 2
  logic [BOARD_W-1:0]   r_board, w_board;
  logic [CELLS-1:0]     r_mask, w_mask;
  logic                 r_win, w_win;
  logic                 r_draw, w_draw;
  logic                 r_ready, w_ready;
  logic                 r_reject, w_reject;
  logic                 r_hit, w_hit;
  logic [MOVES_W-1:0]   r_moves, w_moves;
  logic [IDX_W-1:0]     r_scan_idx, w_scan_idx;
  logic [2:0]           r_cur_state, w_cur_state;

  logic [1:0]           w_pcode;
  logic                 w_user_legal;
  logic                 w_user_move;
  logic                 w_user_illegal;
  logic                 w_auto_move;
  logic [2:0]           w_auto_col;
  logic                 w_do_move;
  logic [2:0]           w_move_col;
  logic [2:0]           w_drop_row;
  logic [CELLS-1:0]     w_win_cells;
  logic                 w_window_hit;

  assign w_pcode = r_player ? 2'b10 : 2'b01;

  // A user column is legal when in range and its top cell is still empty.
  always_comb begin
    w_user_legal = 1'b0;
    if (bus.move_col_i <= 3'd6) begin
      w_user_legal = (r_board[int'(bus.move_col_i) * 2 +: 2] == 2'b00);
    end
  end

  assign w_user_move    = (r_phase == PH_ACCEPT) && bus.move_valid_i && w_user_legal;
  assign w_user_illegal = (r_phase == PH_ACCEPT) && bus.move_valid_i && !w_user_legal;
  assign w_do_move      = w_user_move || w_auto_move;
  assign w_move_col     = w_user_move ? bus.move_col_i : w_auto_col;

  // Landing row is the deepest empty cell of the selected column.
  always_comb begin
    w_drop_row = '0;
    for (int r = 0; r < int'(ROWS); r++) begin
      if (r_board[(r * int'(COLS) + int'(w_move_col)) * 2 +: 2] == 2'b00) begin
        w_drop_row = 3'(r);
      end
    end
  end

  // Decode the scan index into a 4-cell window and test it against the mover's code.
  always_comb begin
    int j;
    int r0;
    int c0;
    int dr;
    int dc;
    int k;
    j            = 0;
    r0           = 0;
    c0           = 0;
    dr           = 0;
    dc           = 1;
    k            = 0;
    w_win_cells  = '0;
    w_window_hit = 1'b1;
    if (r_scan_idx < 7'd24) begin
      j  = int'(r_scan_idx);
      r0 = j / 4;
      c0 = j % 4;
    end else if (r_scan_idx < 7'd45) begin
      j  = int'(r_scan_idx) - 24;
      r0 = j / 7;
      c0 = j % 7;
      dr = 1;
      dc = 0;
    end else if (r_scan_idx < 7'd57) begin
      j  = int'(r_scan_idx) - 45;
      r0 = j / 4;
      c0 = j % 4;
      dr = 1;
      dc = 1;
    end else begin
      j  = int'(r_scan_idx) - 57;
      r0 = j / 4;
      c0 = 3 + (j % 4);
      dr = 1;
      dc = -1;
    end
    for (int n = 0; n < 4; n++) begin
      k = (r0 + n * dr) * int'(COLS) + c0 + n * dc;
      w_win_cells[k] = 1'b1;
      if (r_board[k * 2 +: 2] != w_pcode) begin
        w_window_hit = 1'b0;
      end
    end
  end

`ifdef TURN_TIMEOUT_EN
  localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TMR_W-1:0] r_timer, w_timer;
  logic             w_auto_ok;
  logic             w_timeout;

  // Auto-move target: lowest-indexed column that still has room.
  always_comb begin
    w_auto_col = '0;
    w_auto_ok  = 1'b0;
    for (int c = int'(COLS) - 1; c >= 0; c--) begin
      if (r_board[c * 2 +: 2] == 2'b00) begin
        w_auto_col = 3'(c);
        w_auto_ok  = 1'b1;
      end
    end
  end

  assign w_timeout   = (r_timer == TMR_W'(TIMEOUT_CYCLES - 1));
  assign w_auto_move = (r_phase == PH_ACCEPT) && !w_user_move && w_timeout && w_auto_ok;

  always_comb begin
    w_timer = r_timer;
    case (r_phase)
      PH_IDLE, PH_OVER: if (bus.start_i) w_timer = '0;
      PH_ACCEPT:        w_timer = w_do_move ? '0 : r_timer + TMR_W'(1);
      default:          w_timer = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_timer <= '0;
    else        r_timer <= w_timer;
  end
`else
  logic w_unused_timeout;
  assign w_auto_col       = '0;
  assign w_auto_move      = 1'b0;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
`endif

  // Next-state and next-output logic.
  always_comb begin
    w_phase     = r_phase;
    w_player    = r_player;
    w_board     = r_board;
    w_mask      = r_mask;
    w_win       = r_win;
    w_draw      = r_draw;
    w_ready     = r_ready;
    w_reject    = 1'b0;
    w_hit       = r_hit;
    w_moves     = r_moves;
    w_scan_idx  = r_scan_idx;
    w_cur_state = r_cur_state;
    case (r_phase)
      PH_IDLE, PH_OVER: begin
        if (bus.start_i) begin
          w_phase     = PH_ACCEPT;
          w_player    = 1'b0;
          w_board     = '0;
          w_mask      = '0;
          w_win       = 1'b0;
          w_draw      = 1'b0;
          w_ready     = 1'b1;
          w_hit       = 1'b0;
          w_moves     = '0;
          w_scan_idx  = '0;
          w_cur_state = ST_PLAY1;
        end
      end
      PH_ACCEPT: begin
        w_reject = w_user_illegal;
        if (w_do_move) begin
          w_board[(int'(w_drop_row) * int'(COLS) + int'(w_move_col)) * 2 +: 2] = w_pcode;
          w_moves    = r_moves + MOVES_W'(1);
          w_phase    = PH_SCAN;
          w_ready    = 1'b0;
          w_scan_idx = '0;
          w_hit      = 1'b0;
        end
      end
      PH_SCAN: begin
        if (w_window_hit) w_mask = r_mask | w_win_cells;
        if (r_scan_idx == IDX_W'(LAST_WIN)) begin
          if (r_hit || w_window_hit) begin
            w_phase     = PH_OVER;
            w_win       = 1'b1;
            w_cur_state = ST_OVER;
          end else if (r_moves == MOVES_W'(CELLS)) begin
            w_phase     = PH_OVER;
            w_draw      = 1'b1;
            w_cur_state = ST_OVER;
          end else begin
            w_phase     = PH_ACCEPT;
            w_player    = !r_player;
            w_ready     = 1'b1;
            w_cur_state = r_player ? ST_PLAY1 : ST_PLAY2;
          end
        end else begin
          w_scan_idx = r_scan_idx + IDX_W'(1);
          w_hit      = r_hit || w_window_hit;
        end
      end
      default: w_phase = PH_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_phase     <= PH_IDLE;
      r_player    <= 1'b0;
      r_board     <= '0;
      r_mask      <= '0;
      r_win       <= 1'b0;
      r_draw      <= 1'b0;
      r_ready     <= 1'b0;
      r_reject    <= 1'b0;
      r_hit       <= 1'b0;
      r_moves     <= '0;
      r_scan_idx  <= '0;
      r_cur_state <= ST_IDLE;
    end else begin
      r_phase     <= w_phase;
      r_player    <= w_player;
      r_board     <= w_board;
      r_mask      <= w_mask;
      r_win       <= w_win;
      r_draw      <= w_draw;
      r_ready     <= w_ready;
      r_reject    <= w_reject;
      r_hit       <= w_hit;
      r_moves     <= w_moves;
      r_scan_idx  <= w_scan_idx;
      r_cur_state <= w_cur_state;
    end
  end

  assign bus.board_state_o     = r_board;
  assign bus.winner_play_o     = {{(BOARD_W - CELLS){1'b0}}, r_mask};
  assign bus.theres_a_winner_o = r_win;
  assign bus.draw_o            = r_draw;
  assign bus.move_ready_o      = r_ready;
  assign bus.move_reject_o     = r_reject;
  assign bus.current_state_o   = r_cur_state;
endmodule

// File: tb/tb_connect4_game_ctrl.sv
// Scoreboard bench for connect4_game_ctrl: random and directed games against a grid-level game model.
module tb_connect4_game_ctrl;
  localparam int unsigned TO = 100;
  localparam int E_START  = 0;
  localparam int E_REJECT = 1;
  localparam int E_MOVE   = 2;
  localparam int E_RESULT = 3;

  typedef struct {
    int          kind;
    logic [83:0] board;
    logic [41:0] mask;
    logic [2:0]  state;
    logic        win;
    logic        draw;
    logic        ready;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  connect4_game_ctrl_if bus ();

  connect4_game_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];

  int grid[6][7];
  int mdl_moves;
  int mdl_player;
  bit mdl_over;

  task automatic chk(input string nm, input logic [83:0] act, input logic [83:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm, input string why);
    total++;
    bad++;
    $display("FAIL %s: %s", nm, why);
  endtask

  // ---------------- reference model ----------------
  function automatic void mdl_clear();
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 7; c++) grid[r][c] = 0;
    mdl_moves  = 0;
    mdl_player = 1;
    mdl_over   = 1'b0;
  endfunction

  function automatic logic [83:0] mdl_board();
    logic [83:0] b;
    b = '0;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 7; c++) b[(r * 7 + c) * 2 +: 2] = 2'(grid[r][c]);
    return b;
  endfunction

  // Every cell lying on any straight line of four belonging to player p.
  function automatic logic [41:0] mdl_mask(input int p);
    logic [41:0] m;
    int dr, dc, rr, cc;
    bit all;
    m = '0;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 7; c++)
        for (int d = 0; d < 4; d++) begin
          dr  = (d == 0) ? 0 : 1;
          dc  = (d == 0) ? 1 : (d == 1) ? 0 : (d == 2) ? 1 : -1;
          all = 1'b1;
          for (int n = 0; n < 4; n++) begin
            rr = r + n * dr;
            cc = c + n * dc;
            if (rr < 0 || rr > 5 || cc < 0 || cc > 6) all = 1'b0;
            else if (grid[rr][cc] != p) all = 1'b0;
          end
          if (all)
            for (int n = 0; n < 4; n++) m[(r + n * dr) * 7 + c + n * dc] = 1'b1;
        end
    return m;
  endfunction

  function automatic void model_move(input int col);
    exp_t e;
    int row;
    logic [41:0] m;
    e.kind  = E_REJECT;
    e.board = mdl_board();
    e.mask  = '0;
    e.state = 3'(mdl_player);
    e.win   = 1'b0;
    e.draw  = 1'b0;
    e.ready = 1'b1;
    row = -1;
    if (col <= 6)
      for (int r = 0; r < 6; r++) if (grid[r][col] == 0) row = r;
    if (row < 0) begin
      exp_q.push_back(e);
      return;
    end
    grid[row][col] = mdl_player;
    mdl_moves++;
    e.kind  = E_MOVE;
    e.board = mdl_board();
    e.ready = 1'b0;
    exp_q.push_back(e);
    m = mdl_mask(mdl_player);
    e.kind = E_RESULT;
    e.mask = m;
    if (m != '0) begin
      e.state = 3'd3; e.win = 1'b1; mdl_over = 1'b1;
    end else if (mdl_moves == 42) begin
      e.state = 3'd3; e.draw = 1'b1; mdl_over = 1'b1;
    end else begin
      mdl_player = 3 - mdl_player;
      e.state = 3'(mdl_player);
      e.ready = 1'b1;
    end
    exp_q.push_back(e);
  endfunction

  // ---------------- monitor ----------------
  task automatic pop_check(input int kind);
    exp_t e;
    string kn;
    kn = (kind == E_START) ? "start" : (kind == E_REJECT) ? "reject" :
         (kind == E_MOVE) ? "move" : "result";
    if (exp_q.size() == 0) begin
      fail_now(kn, "DUT event with no expected entry queued");
      return;
    end
    e = exp_q.pop_front();
    chk({kn, ".kind"},   84'(kind), 84'(e.kind));
    chk({kn, ".board"},  bus.board_state_o, e.board);
    chk({kn, ".mask"},   bus.winner_play_o, 84'(e.mask));
    chk({kn, ".state"},  84'(bus.current_state_o), 84'(e.state));
    chk({kn, ".winner"}, 84'(bus.theres_a_winner_o), 84'(e.win));
    chk({kn, ".draw"},   84'(bus.draw_o), 84'(e.draw));
    chk({kn, ".ready"},  84'(bus.move_ready_o), 84'(e.ready));
  endtask

  always @(negedge clk) begin : mon
    bit       prev_ready;
    bit [2:0] prev_state;
    bit       in_scan;
    int       lo_cnt;
    if (!rst_n) begin
      prev_ready = 1'b0;
      prev_state = 3'd0;
      in_scan    = 1'b0;
      lo_cnt     = 0;
    end else begin
      if (bus.move_reject_o) pop_check(E_REJECT);
      if ((prev_state == 3'd0 || prev_state == 3'd3) && bus.current_state_o == 3'd1)
        pop_check(E_START);
      if (prev_ready && !bus.move_ready_o && bus.current_state_o inside {3'd1, 3'd2}) begin
        pop_check(E_MOVE);
        in_scan = 1'b1;
        lo_cnt  = 0;
      end
      if (in_scan) begin
        if (bus.move_ready_o || bus.current_state_o == 3'd3) begin
          chk("scan_busy_cycles", 84'(lo_cnt), 84'(69));
          pop_check(E_RESULT);
          in_scan = 1'b0;
        end else begin
          lo_cnt++;
          if (lo_cnt > 200) begin
            fail_now("scan_end", "no result within 200 cycles");
            in_scan = 1'b0;
          end
        end
      end
      prev_ready = bus.move_ready_o;
      prev_state = bus.current_state_o;
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_reset();
    rst_n            = 1'b0;
    bus.start_i      = 1'b0;
    bus.move_valid_i = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("rst.board",  bus.board_state_o, 84'(0));
    chk("rst.mask",   bus.winner_play_o, 84'(0));
    chk("rst.winner", 84'(bus.theres_a_winner_o), 84'(0));
    chk("rst.draw",   84'(bus.draw_o), 84'(0));
    chk("rst.state",  84'(bus.current_state_o), 84'(0));
    chk("rst.ready",  84'(bus.move_ready_o), 84'(0));
    chk("rst.reject", 84'(bus.move_reject_o), 84'(0));
    rst_n = 1'b1;
    mdl_clear();
    mdl_over = 1'b1;
  endtask

  task automatic pulse_start();
    exp_t e;
    mdl_clear();
    e.kind = E_START; e.board = '0; e.mask = '0; e.state = 3'd1;
    e.win = 1'b0; e.draw = 1'b0; e.ready = 1'b1;
    exp_q.push_back(e);
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
  endtask

  task automatic wait_ready(output bit ok);
    int n;
    n = 0;
    while (!bus.move_ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    ok = bus.move_ready_o;
    if (!ok) fail_now("ready_wait", "move_ready_o stayed low for 200 cycles");
  endtask

  task automatic play(input int col, output bit ok);
    wait_ready(ok);
    if (!ok) return;
    model_move(col);
    bus.move_col_i   = 3'(col);
    bus.move_valid_i = 1'b1;
    @(negedge clk);
    bus.move_valid_i = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (exp_q.size() != 0 && n < 300);
    if (exp_q.size() != 0) fail_now("drain", "expected events still pending after 300 cycles");
  endtask

  task automatic new_game();
    wait_drain();
    if (!mdl_over) do_reset();
    pulse_start();
  endtask

  initial begin : watchdog
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit ok;
    logic [41:0] m;
    bus.start_i      = 1'b0;
    bus.move_valid_i = 1'b0;
    bus.move_col_i   = 3'd0;
    repeat (3) @(negedge clk);
    do_reset();
    pulse_start();

    // Two pieces stacked in column 3.
    play(3, ok);
    play(3, ok);
    wait_drain();
    chk("p1_col3_bottom", 84'(bus.board_state_o[77:76]), 84'(2'b01));
    chk("p2_col3_above",  84'(bus.board_state_o[63:62]), 84'(2'b10));

    // Fill column 0, then overflow it and use an out-of-range column.
    new_game();
    for (int i = 0; i < 6; i++) play(0, ok);
    play(0, ok);
    play(7, ok);
    wait_drain();
    chk("reject_one_cycle", 84'(bus.move_reject_o), 84'(0));

    // Player 1 horizontal win on the bottom row.
    new_game();
    play(0, ok); play(0, ok); play(1, ok); play(1, ok);
    play(2, ok); play(2, ok); play(3, ok);
    wait_drain();
    m = '0;
    m[38:35] = 4'hF;
    chk("win.state", 84'(bus.current_state_o), 84'(3));
    chk("win.mask",  bus.winner_play_o, 84'(m));
    bus.move_col_i   = 3'd4;
    bus.move_valid_i = 1'b1;
    repeat (5) @(negedge clk);
    bus.move_valid_i = 1'b0;
    chk("over.ignore_board", bus.board_state_o, mdl_board());
    chk("over.ignore_ready", 84'(bus.move_ready_o), 84'(0));

    // Idle turn straight after a start from GAMEOVER.
    pulse_start();
`ifdef TURN_TIMEOUT_EN
    model_move(0);
    repeat (99) @(negedge clk);
    chk("timeout.before", bus.board_state_o, 84'(0));
    @(negedge clk);
    chk("timeout.auto_col0", 84'(bus.board_state_o[71:70]), 84'(2'b01));
    wait_drain();
`else
    repeat (1000) @(negedge clk);
    chk("idle.board", bus.board_state_o, 84'(0));
    chk("idle.state", 84'(bus.current_state_o), 84'(1));
    chk("idle.ready", 84'(bus.move_ready_o), 84'(1));
`endif

    // Reset in scan cycle 30, then a clean game.
    new_game();
    play(2, ok);
    repeat (29) @(negedge clk);
    do_reset();
    pulse_start();
    play(4, ok);
    wait_drain();
    chk("after_rst.col4", 84'(bus.board_state_o[79:78]), 84'(2'b01));
    chk("after_rst.col2", 84'(bus.board_state_o[75:74]), 84'(2'b00));

    // Random games against the model.
    for (int g = 0; g < 6; g++) begin
      new_game();
      for (int n = 0; n < 300 && !mdl_over; n++) begin
        play(int'($urandom_range(0, 7)), ok);
        if (!ok) break;
      end
    end
    wait_drain();
    chk("queue_drained", 84'(exp_q.size()), 84'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/connect4_game_ctrl.md
# connect4_game_ctrl

Game controller and board-state owner for the Connect4 display path. Accepts column moves from the player-input logic and drops each piece into the lowest empty row. After every move it scans the board sequentially for four-in-a-row and drives the game state, packed board, winning-cell mask and winner flag consumed by the VGA pixel generator.

## Interface
Parameters:
- TIMEOUT_CYCLES, 500_000_000: idle cycles per turn before an auto-move (10 s at 50 MHz); used only with TURN_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; one clock domain; reset is synchronous and active-low.
- rst_n  in  1  synchronous active-low reset.
- start_i  in  1  one-cycle pulse; starts a new game from IDLE or GAMEOVER.
- move_valid_i  in  1  move request; sampled only while move_ready_o=1.
- move_col_i  in  3  requested column, 0..6 (0 = leftmost).
- move_ready_o  out  1  controller can accept a move.
- move_reject_o  out  1  one-cycle pulse: last request was illegal.
- board_state_o  out  84  2 bits per cell; cell (row,col) at [(row*7+col)*2 +: 2]; row 0 = top; 00 empty, 01 player 1, 10 player 2.
- winner_play_o  out  84  bit row*7+col set for each cell in a winning line; bits 83:42 always 0.
- theres_a_winner_o  out  1  the game ended with a win.
- draw_o  out  1  the game ended with a full board and no win.
- current_state_o  out  3  0 IDLE, 1 PLAY1, 2 PLAY2, 3 GAMEOVER; codes 4..7 never driven.

## Operation
- Reset values: board_state_o=0, winner_play_o=0, theres_a_winner_o=0, draw_o=0, current_state_o=IDLE, move_ready_o=0, move_reject_o=0, move count=0, timer=0, scan index=0.
- Internal phases while in PLAY1/PLAY2:
  - ACCEPT: move_ready_o=1.
  - SCAN: move_ready_o=0.
- IDLE: start_i clears board, mask, flags and move count, then enters PLAY1/ACCEPT. Player 1 always starts.
- ACCEPT, move_valid_i=1 with a legal column: the column is legal when move_col_i≤6 and row 0 of that column is empty.
  - Write the current player's code into the highest-numbered empty row of that column.
  - Increment the move count.
  - Enter SCAN with scan index 0.
- ACCEPT, move_valid_i=1 with an illegal column: pulse move_reject_o. Board, state and timer are unchanged; the controller stays in ACCEPT.
- SCAN: evaluates one 4-cell window per cycle, indices 0..68:
  - 0–23: horizontal. Row r = i/4, start column c = i%4.
  - 24–44: vertical. Column = (i-24)%7, start row = (i-24)/7, cells going down.
  - 45–56: diagonal down-right. Start row (i-45)/4, start column (i-45)%4.
  - 57–68: diagonal down-left. Start row (i-57)/4, start column 3+(i-57)%4.
  - A window hits when all 4 cells equal the code of the player who just moved. On a hit, OR the window's cells into winner_play_o. Later hits still accumulate, so overlapping lines are all highlighted.
- End of scan (index 68 evaluated):
  - Any hit: GAMEOVER, theres_a_winner_o=1.
  - Else, move count = 42: GAMEOVER, draw_o=1.
  - Else: switch player (PLAY1↔PLAY2), return to ACCEPT, clear the timer.
- Ignored inputs:
  - start_i is ignored in PLAY1/PLAY2.
  - move_valid_i is ignored whenever move_ready_o=0.
- GAMEOVER: board, mask and flags hold. start_i behaves exactly as it does from IDLE.
- Reset asserted in any phase, including mid-scan, overrides all other inputs. All outputs take their reset values.

## Timing
- A move is accepted on the edge where move_valid_i && move_ready_o. Call the accept cycle T.
- board_state_o shows the new piece from T+1.
- move_ready_o=0 during T+1..T+69; the scan occupies T+1..T+69.
- Updated current_state_o, theres_a_winner_o and draw_o are visible at T+70. move_ready_o returns to 1 at T+70 only if play continues.
- move_reject_o is high exactly in cycle T+1 after an illegal request.
- start_i at cycle S: PLAY1 and move_ready_o=1 visible at S+1.

## Configuration
- TURN_TIMEOUT_EN defined:
  - A timer counts every ACCEPT cycle without an accepted move.
  - When the timer reaches TIMEOUT_CYCLES-1, the controller injects a move into the lowest-indexed non-full column. The auto-move has the same timing as a user move.
  - The timer clears on every accept.
  - An illegal request does not clear the timer.
- TURN_TIMEOUT_EN undefined: no timer logic; TIMEOUT_CYCLES is unused; turns wait indefinitely.

## Test plan
- Reset, then start_i pulse: all outputs at reset values; next cycle current_state_o=1, move_ready_o=1.
- P1 plays col 3, then P2 plays col 3:
  - board_state_o[77:76]=01 and [63:62]=10.
  - current_state_o=2 at T+70 after the first move.
  - move_ready_o=0 for exactly 69 cycles after each move.
- Six moves into col 0, then a 7th into col 0: move_reject_o high for 1 cycle; board and state unchanged.
- move_col_i=7: move_reject_o high for 1 cycle; board and state unchanged.
- P1 plays cols 0,1,2,3 and P2 plays cols 0,1,2 (interleaved):
  - After P1's 4th move scan: current_state_o=3 and theres_a_winner_o=1.
  - winner_play_o has only bits 35..38 set.
  - A subsequent move_valid_i is ignored.
- With TURN_TIMEOUT_EN and TIMEOUT_CYCLES=100: no input after start → after 100 cycles, board_state_o[71:70]=01 and the scan follows. Without the macro: the board stays empty for 1000 cycles.
- rst_n low during SCAN cycle 30: the next cycle shows all reset values; start_i then begins a clean game.
